// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_DROP  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        FETCH = ST_FETCH,
        DROP  = ST_DROP,
        HOLD  = ST_HOLD
    } fetch_state_t;

    localparam logic [FETCH_XLEN-1:0] PC_INC            = FETCH_XLEN'(4);
    localparam logic [FETCH_XLEN-1:0] NOP_INSTR_DEFAULT = '0;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] instr;
        logic [FETCH_XLEN-1:0] pc_plus4;
        logic                  valid;
    } if_id_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, and an idle write inserts a bubble.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [FETCH_XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   write_en,
    input  logic   deliver,
    input  if_id_t in_data,
    output if_id_t out_data
);

    if_id_t stage_q;
    if_id_t stage_d;
    if_id_t bubble;

    always_comb begin
        bubble   = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        stage_d  = stage_q;
        if (flush) begin
            stage_d = bubble;
        end else if (write_en) begin
            stage_d = deliver ? in_data : bubble;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_data = stage_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with req/ack memory handshake, PC, redirect handling and IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           XLEN      = FETCH_XLEN,
    parameter logic [XLEN-1:0]       RESET_PC  = '0,
    parameter logic [FETCH_XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            pc_ld,
    input  logic            IF_ID_write,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic            if_id_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushes,
    output logic [31:0]     perf_stall_cycles,
`endif
    output logic            fetch_busy
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [XLEN-1:0] pc_plus4;
    logic            consume;
    logic            deliver;
    if_id_t          fetched;
    if_id_t          if_id_out;

    assign consume  = pc_ld & IF_ID_write;
    assign pc_plus4 = pc_q + PC_INC;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        buf_d   = buf_q;
        deliver = 1'b0;
        fetched = '{instr: imem_rdata, pc_plus4: pc_plus4, valid: 1'b1};
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    if (flush) begin
                        pc_d = redirect_pc;
                    end else if (consume) begin
                        deliver = 1'b1;
                        pc_d    = pc_plus4;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = HOLD;
                    end
                end else if (flush) begin
                    // Address must stay put until the outstanding request is acked.
                    pend_d  = redirect_pc;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    pc_d    = flush ? redirect_pc : pend_q;
                    state_d = FETCH;
                end else if (flush) begin
                    pend_d = redirect_pc;
                end
            end
            HOLD: begin
                fetched.instr = buf_q;
                if (flush) begin
                    buf_d   = '0;
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (consume) begin
                    deliver = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
        end
    end

    assign imem_req   = rst_n && (state_q != HOLD);
    assign imem_addr  = pc_q;
    assign fetch_busy = !(((state_q == FETCH) && imem_ack) || (state_q == HOLD));

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .write_en (IF_ID_write),
        .deliver  (deliver),
        .in_data  (fetched),
        .out_data (if_id_out)
    );

    assign if_id_instr    = if_id_out.instr;
    assign if_id_pc_plus4 = if_id_out.pc_plus4;
    assign if_id_valid    = if_id_out.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_cnt_q, fetched_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetched_cnt_d = sat_inc(fetched_cnt_q, deliver);
        flush_cnt_d   = sat_inc(flush_cnt_q, flush);
        stall_cnt_d   = sat_inc(stall_cnt_q, fetch_busy || (state_q == HOLD));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_cnt_q <= '0;
            flush_cnt_q   <= '0;
            stall_cnt_q   <= '0;
        end else begin
            fetched_cnt_q <= fetched_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign perf_fetched      = fetched_cnt_q;
    assign perf_flushes      = flush_cnt_q;
    assign perf_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, hold, redirects during a request, flush vs hold, async reset.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        pc_ld;
    logic        IF_ID_write;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_busy;

    int n_checks;
    int n_fail;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .pc_ld          (pc_ld),
        .IF_ID_write    (IF_ID_write),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_busy     (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {16'hBEEF, addr[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic v);
        check({tag, ".instr"}, if_id_instr, instr);
        check({tag, ".pc4"}, if_id_pc_plus4, pc4);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        redirect_pc = '0;
        pc_ld       = 1'b0;
        IF_ID_write = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;

        #3;
        check("rst.req", {31'd0, imem_req}, 32'd0);
        check_ifid("rst.ifid", 32'h0, 32'h0, 1'b0);
        #5 rst_n = 1'b1;

        // Zero-wait streaming from RESET_PC
        pc_ld = 1'b1; IF_ID_write = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(32'(i * 4));
            #1;
            check($sformatf("t1.addr%0d", i), imem_addr, 32'(i * 4));
            check($sformatf("t1.busy%0d", i), {31'd0, fetch_busy}, 32'd0);
            tick();
            check_ifid($sformatf("t1.ifid%0d", i), mem_word(32'(i * 4)), 32'(i * 4 + 4), 1'b1);
        end

        // Ack while decode is stalled: instruction parks in HOLD
        pc_ld = 1'b0; IF_ID_write = 1'b0;
        imem_ack = 1'b1; imem_rdata = mem_word(32'h10);
        #1;
        check("t2.addr", imem_addr, 32'h10);
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("t2.req%0d", i), {31'd0, imem_req}, 32'd0);
            check($sformatf("t2.busy%0d", i), {31'd0, fetch_busy}, 32'd0);
            tick();
            check_ifid($sformatf("t2.hold%0d", i), mem_word(32'hC), 32'h10, 1'b1);
        end
        pc_ld = 1'b1; IF_ID_write = 1'b1;
        tick();
        check_ifid("t2.release", mem_word(32'h10), 32'h14, 1'b1);
        #1;
        check("t2.req_resume", {31'd0, imem_req}, 32'd1);
        check("t2.addr_resume", imem_addr, 32'h14);
        check("t2.busy_noack", {31'd0, fetch_busy}, 32'd1);

        // Flush while a request is outstanding: old address held, response dropped
        flush = 1'b1; redirect_pc = 32'h100;
        tick();
        check_ifid("t3.flush", 32'h0, 32'h0, 1'b0);
        flush = 1'b0;
        #1;
        check("t3.addr_drop0", imem_addr, 32'h14);
        check("t3.req_drop0", {31'd0, imem_req}, 32'd1);
        tick();
        check("t3.valid_wait", {31'd0, if_id_valid}, 32'd0);
        imem_ack = 1'b1; imem_rdata = mem_word(32'h14);
        #1;
        check("t3.addr_drop1", imem_addr, 32'h14);
        tick();
        check("t3.valid_stale", {31'd0, if_id_valid}, 32'd0);
        imem_rdata = mem_word(32'h100);
        #1;
        check("t3.addr_new", imem_addr, 32'h100);
        tick();
        check_ifid("t3.ifid_new", mem_word(32'h100), 32'h104, 1'b1);

        // Two redirects while dropping: the later one wins
        imem_ack = 1'b0; flush = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_pc = 32'h200;
        #1;
        check("t4.addr_drop0", imem_addr, 32'h104);
        tick();
        flush = 1'b0; imem_ack = 1'b1; imem_rdata = mem_word(32'h104);
        #1;
        check("t4.addr_drop1", imem_addr, 32'h104);
        tick();
        check("t4.valid_stale", {31'd0, if_id_valid}, 32'd0);
        imem_rdata = mem_word(32'h200);
        #1;
        check("t4.addr_new", imem_addr, 32'h200);
        tick();
        check_ifid("t4.ifid_new", mem_word(32'h200), 32'h204, 1'b1);

        // Flush coinciding with ack beats IF/ID hold
        flush = 1'b1; redirect_pc = 32'h300; pc_ld = 1'b0; IF_ID_write = 1'b0;
        imem_rdata = mem_word(32'h204);
        tick();
        check_ifid("t5.ifid", 32'h0, 32'h0, 1'b0);
        flush = 1'b0; imem_ack = 1'b0;
        #1;
        check("t5.addr", imem_addr, 32'h300);

        // Asynchronous reset in the middle of DROP
        flush = 1'b1; redirect_pc = 32'h400;
        tick();
        flush = 1'b0;
        #1;
        check("t6.addr_drop", imem_addr, 32'h300);
        check("t6.req_drop", {31'd0, imem_req}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6.req_rst", {31'd0, imem_req}, 32'd0);
        check("t6.addr_rst", imem_addr, 32'h0);
        check_ifid("t6.ifid_rst", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pc_ld = 1'b1; IF_ID_write = 1'b1;
        imem_ack = 1'b1; imem_rdata = mem_word(32'h0);
        #1;
        check("t6.addr_post", imem_addr, 32'h0);
        check("t6.req_post", {31'd0, imem_req}, 32'd1);
        tick();
        check_ifid("t6.ifid_post", mem_word(32'h0), 32'h4, 1'b1);
        imem_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Consumes the hazard controls `flush`, `pc_ld` and `IF_ID_write` together with a redirect target.
- Owns the PC and issues variable-latency requests to instruction memory over a req/ack handshake.
- Delivers instructions, with their PC+4, to decode, and inserts NOP bubbles on flush or starvation.

Parameters:
- XLEN, 32, instruction and address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, encoding written into IF/ID on a bubble or flush.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  squash the fetched instruction and redirect the PC (taken jump/branch).
- redirect_pc  in  XLEN  new PC; valid when flush=1.
- pc_ld  in  1  PC may advance.
- IF_ID_write  in  1  IF/ID may update.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address; stable while imem_req=1 until ack.
- imem_ack  in  1  one-cycle response strobe; may coincide with the first req cycle.
- imem_rdata  in  XLEN  instruction; valid with imem_ack.
- if_id_instr  out  XLEN  registered instruction to decode.
- if_id_pc_plus4  out  XLEN  registered PC+4 of that instruction.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- fetch_busy  out  1  no instruction available this cycle; informational to the hazard logic.

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc=RESET_PC, state=FETCH, hold buffer cleared.
  - if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0.
  - imem_req is forced to 0 while rst_n=0.
- consume = pc_ld & IF_ID_write. Addresses wrap modulo 2^XLEN. pc+4 is XLEN bits; overflow is discarded.
- FETCH state: imem_req=1, imem_addr=pc. At the clock edge:
  - ack & flush: discard rdata, pc<=redirect_pc, stay in FETCH.
  - ack & consume: IF/ID<={rdata, pc+4, valid=1}, pc<=pc+4, stay in FETCH. Zero-wait memory therefore gives 1 instruction/cycle.
  - ack & !consume: buf<=rdata, go to HOLD.
  - !ack & flush: the address must stay stable, so pend<=redirect_pc and go to DROP.
  - !ack & !flush: stay in FETCH.
- DROP state: imem_req=1, imem_addr=old pc.
  - flush: pend<=redirect_pc (latest redirect wins).
  - ack: discard rdata, pc<=pend (or redirect_pc if flush is also high that cycle), go to FETCH.
- HOLD state: imem_req=0.
  - flush: drop buf, pc<=redirect_pc, go to FETCH.
  - else consume: IF/ID<={buf, pc+4, 1}, pc<=pc+4, go to FETCH.
  - else stay in HOLD.
- IF/ID update priority:
  1. flush → {NOP_INSTR, 0, valid=0}.
  2. IF_ID_write=0 → hold the current contents.
  3. IF_ID_write=1 with an instruction delivered this edge → load it.
  4. IF_ID_write=1 with nothing delivered → bubble {NOP_INSTR, 0, 0}.
- fetch_busy=1 unless (FETCH & imem_ack) or HOLD. It is combinational.
- Redirect latency: the first instruction from redirect_pc reaches IF/ID no earlier than 1 cycle after the flush edge.
- No instruction from the squashed path may ever reach IF/ID with valid=1.
- Reset mid-request: the state and the outstanding request are abandoned. An imem_ack arriving after reset release while in FETCH is treated as the response for RESET_PC. The memory model must not deliver stale acks across reset.

Optional Feature:
- FETCH_PERF_CNT_EN: adds output ports perf_fetched[31:0] (instructions loaded into IF/ID with valid=1), perf_flushes[31:0] (cycles with flush=1) and perf_stall_cycles[31:0] (cycles with fetch_busy=1 or state=HOLD).
- The counters reset to 0, saturate at 32'hFFFF_FFFF, and have no effect on fetch behaviour.
- Without the macro these ports and counters do not exist.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {FETCH, DROP, HOLD}.
  - PC_INC=4.
  - default NOP_INSTR.
  - struct if_id_t {instr, pc_plus4, valid}.
- Sub-module if_id_reg: implements the IF/ID priority rules (flush / hold / load / bubble) and takes an if_id_t input plus a deliver strobe.
- fetch_unit: instantiates if_id_reg and contains the PC, the FSM and the hold buffer.

Test Plan:
1. Zero-wait memory, consume=1, reset PC 0, four cycles → imem_addr 0,4,8,C; if_id_pc_plus4 4,8,C,10; valid=1 each cycle.
2. ack on cycle 1 with IF_ID_write=0 and pc_ld=0 for 3 cycles → HOLD, imem_req=0, IF/ID unchanged. Release → buffered instr loaded, pc+4, FETCH resumes.
3. Flush with redirect_pc=0x100 while FETCH awaits ack (ack 2 cycles later) → imem_addr stays at the old pc until ack; rdata discarded; next request at 0x100; no valid=1 from the old path.
4. Two flushes during DROP (0x100, then 0x200) → next fetch address 0x200.
5. Flush coinciding with ack and IF_ID_write=0 → IF/ID={NOP,0,0} (flush beats hold); pc=redirect_pc.
6. Assert rst_n=0 mid-DROP → outputs at reset values immediately (async); after release, the first imem_addr = RESET_PC.
